// File: rtl/lab1_imul_pkg.sv
// Shared definitions for the lab1 integer multiplier front-end.
//   port_id_t       : requester identifier carried in the tag queue
//   PORT0 / PORT1   : requester identifier values
//   IMUL_*_NBITS    : multiplier request/response message widths
package lab1_imul_pkg;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  localparam int unsigned IMUL_REQ_NBITS  = 64;
  localparam int unsigned IMUL_RESP_NBITS = 32;

endpackage

// File: rtl/lab1_imul_tag_queue.sv
// FIFO of requester IDs for operations in flight inside the multiplier.
//   clk, reset         : clock, synchronous active-high reset
//   enq_en, enq_data   : push an ID (ignored when full)
//   deq_en, deq_data   : pop the head ID (ignored when empty); deq_data is the head
//   full, empty        : occupancy flags
//   count              : current occupancy
module lab1_imul_tag_queue
  import lab1_imul_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enq_en,
  input  port_id_t        enq_data,
  input  logic            deq_en,
  output port_id_t        deq_data,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  port_id_t            data_q [DEPTH];
  logic     [PtrW-1:0] head_q, head_d;
  logic     [PtrW-1:0] tail_q, tail_d;
  logic     [CntW-1:0] count_q, count_d;
  logic                do_enq, do_deq;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign deq_data = data_q[head_q];

  assign do_enq = enq_en && !full;
  assign do_deq = deq_en && !empty;

  always_comb begin
    head_d  = do_deq ? ptr_inc(head_q) : head_q;
    tail_d  = do_enq ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_enq) data_q[tail_q] <= enq_data;
  end

endmodule

// File: rtl/lab1_imul_req_arb.sv
// Round-robin two-port arbiter and response router in front of the lab1 multiplier.
//   clk, reset                       : clock, synchronous active-high reset
//   inN_req_{val,rdy,msg}            : requester N operands {a, b}
//   outN_resp_{val,rdy,msg}          : product returned to requester N
//   mul_req_{val,rdy,msg}            : merged request stream to the multiplier
//   mul_resp_{val,rdy,msg}           : product stream from the multiplier
// Purely combinational between the two sides; a tag queue remembers which
// requester owns each in-flight product.
module lab1_imul_req_arb
  import lab1_imul_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       in0_req_val,
  output logic                       in0_req_rdy,
  input  logic [IMUL_REQ_NBITS-1:0]  in0_req_msg,
  input  logic                       in1_req_val,
  output logic                       in1_req_rdy,
  input  logic [IMUL_REQ_NBITS-1:0]  in1_req_msg,

  output logic                       out0_resp_val,
  input  logic                       out0_resp_rdy,
  output logic [IMUL_RESP_NBITS-1:0] out0_resp_msg,
  output logic                       out1_resp_val,
  input  logic                       out1_resp_rdy,
  output logic [IMUL_RESP_NBITS-1:0] out1_resp_msg,

  output logic                       mul_req_val,
  input  logic                       mul_req_rdy,
  output logic [IMUL_REQ_NBITS-1:0]  mul_req_msg,
  input  logic                       mul_resp_val,
  output logic                       mul_resp_rdy,
  input  logic [IMUL_RESP_NBITS-1:0] mul_resp_msg
);

  port_id_t                   prio_q, prio_d;
  port_id_t                   gnt_id;
  port_id_t                   head_id;
  logic                       any_val;
  logic                       full, empty;
  logic                       req_ok, resp_ok;
  logic                       req_fire, resp_fire;
  logic [$clog2(DEPTH+1)-1:0] q_count;

  // Grant looks only at the valids and the priority pointer.
  always_comb begin
    gnt_id = PORT0;
    if (in0_req_val && in1_req_val) gnt_id = prio_q;
    else if (in1_req_val)           gnt_id = PORT1;
  end

  assign any_val = in0_req_val || in1_req_val;

  // No bypass when full: a same-cycle dequeue does not reopen the request path.
  assign req_ok      = !reset && !full;
  assign mul_req_val = any_val && req_ok;
  assign mul_req_msg = (gnt_id == PORT1) ? in1_req_msg : in0_req_msg;
  assign in0_req_rdy = any_val && (gnt_id == PORT0) && mul_req_rdy && req_ok;
  assign in1_req_rdy = any_val && (gnt_id == PORT1) && mul_req_rdy && req_ok;
  assign req_fire    = mul_req_val && mul_req_rdy;

  assign resp_ok       = !reset && !empty;
  assign out0_resp_val = resp_ok && (head_id == PORT0) && mul_resp_val;
  assign out1_resp_val = resp_ok && (head_id == PORT1) && mul_resp_val;
  assign mul_resp_rdy  = resp_ok && ((head_id == PORT1) ? out1_resp_rdy : out0_resp_rdy);
  assign out0_resp_msg = mul_resp_msg;
  assign out1_resp_msg = mul_resp_msg;
  assign resp_fire     = mul_resp_val && mul_resp_rdy;

  always_comb begin
    prio_d = prio_q;
    if (req_fire) prio_d = ~gnt_id;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= PORT0;
    else       prio_q <= prio_d;
  end

  lab1_imul_tag_queue #(
    .DEPTH (DEPTH)
  ) u_tag_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_en   (req_fire),
    .enq_data (gnt_id),
    .deq_en   (resp_fire),
    .deq_data (head_id),
    .full     (full),
    .empty    (empty),
    .count    (q_count)
  );

  // A product with no owner means the multiplier and this block disagree.
  resp_without_tag_a: assert property (@(posedge clk) disable iff (reset)
    !(mul_resp_val && empty));

  function automatic string line_trace();
    return $sformatf("g%s p%0d q%0d", mul_req_val ? (gnt_id ? "1" : "0") : "-",
                     prio_q, q_count);
  endfunction

endmodule

// File: tb/tb_lab1_imul_req_arb.sv
module tb_lab1_imul_req_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_req_val, in0_req_rdy, in1_req_val, in1_req_rdy;
  logic [63:0] in0_req_msg, in1_req_msg, mul_req_msg;
  logic        out0_resp_val, out0_resp_rdy, out1_resp_val, out1_resp_rdy;
  logic [31:0] out0_resp_msg, out1_resp_msg, mul_resp_msg;
  logic        mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lab1_imul_req_arb #(.DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .in0_req_val   (in0_req_val),
    .in0_req_rdy   (in0_req_rdy),
    .in0_req_msg   (in0_req_msg),
    .in1_req_val   (in1_req_val),
    .in1_req_rdy   (in1_req_rdy),
    .in1_req_msg   (in1_req_msg),
    .out0_resp_val (out0_resp_val),
    .out0_resp_rdy (out0_resp_rdy),
    .out0_resp_msg (out0_resp_msg),
    .out1_resp_val (out1_resp_val),
    .out1_resp_rdy (out1_resp_rdy),
    .out1_resp_msg (out1_resp_msg),
    .mul_req_val   (mul_req_val),
    .mul_req_rdy   (mul_req_rdy),
    .mul_req_msg   (mul_req_msg),
    .mul_resp_val  (mul_resp_val),
    .mul_resp_rdy  (mul_resp_rdy),
    .mul_resp_msg  (mul_resp_msg)
  );

  // Inputs change 1 time unit after the rising edge; checks follow after a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in0_req_val = 1'b0; in0_req_msg = '0;
    in1_req_val = 1'b0; in1_req_msg = '0;
    out0_resp_rdy = 1'b1; out1_resp_rdy = 1'b1;
    mul_req_rdy = 1'b1;
    mul_resp_val = 1'b0; mul_resp_msg = '0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    in0_req_val = 1'b1; in1_req_val = 1'b1;
    tick(); #1;
    vectors++;
    if ({in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val, out1_resp_val}
        !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val,
                out1_resp_val});
    end
    tick();
    reset = 1'b0;
    idle();
    #1;
    vectors++;
    if ({dut.prio_q, mul_resp_rdy, mul_req_val} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_state: got prio/resp_rdy/req_val %b expected 000",
               {dut.prio_q, mul_resp_rdy, mul_req_val});
    end
  endtask

  task automatic test_single_port();
    apply_reset();
    in0_req_val = 1'b1; in0_req_msg = {32'd3, 32'd4};
    #1;
    vectors++;
    if ({in0_req_rdy, in1_req_rdy, mul_req_val} !== 3'b101 || mul_req_msg !== {32'd3, 32'd4})
    begin
      miscompares++;
      $display("FAIL single_req: got rdy0/rdy1/val %b msg %h expected 101 msg %h",
               {in0_req_rdy, in1_req_rdy, mul_req_val}, mul_req_msg, {32'd3, 32'd4});
    end
    tick();
    in0_req_val = 1'b0;
    mul_resp_val = 1'b1; mul_resp_msg = 32'd12;
    #1;
    vectors++;
    if ({out0_resp_val, out1_resp_val, mul_resp_rdy} !== 3'b101 || out0_resp_msg !== 32'd12)
    begin
      miscompares++;
      $display("FAIL single_resp: got v0/v1/rdy %b msg %0d expected 101 msg 12",
               {out0_resp_val, out1_resp_val, mul_resp_rdy}, out0_resp_msg);
    end
    tick();
    mul_resp_val = 1'b0;
  endtask

  task automatic test_contention();
    apply_reset();
    in0_req_val = 1'b1; in0_req_msg = {32'd2, 32'd5};
    in1_req_val = 1'b1; in1_req_msg = {32'd7, 32'd6};
    #1;
    vectors++;
    if ({in0_req_rdy, in1_req_rdy} !== 2'b10 || mul_req_msg !== {32'd2, 32'd5}) begin
      miscompares++;
      $display("FAIL contend_first: got rdy %b msg %h expected 10 msg %h",
               {in0_req_rdy, in1_req_rdy}, mul_req_msg, {32'd2, 32'd5});
    end
    tick();
    in0_req_val = 1'b0;
    #1;
    vectors++;
    if ({in0_req_rdy, in1_req_rdy} !== 2'b01 || mul_req_msg !== {32'd7, 32'd6}) begin
      miscompares++;
      $display("FAIL contend_second: got rdy %b msg %h expected 01 msg %h",
               {in0_req_rdy, in1_req_rdy}, mul_req_msg, {32'd7, 32'd6});
    end
    tick();
    in1_req_val = 1'b0;
    mul_resp_val = 1'b1; mul_resp_msg = 32'd10;
    #1;
    vectors++;
    if ({out0_resp_val, out1_resp_val} !== 2'b10 || out0_resp_msg !== 32'd10) begin
      miscompares++;
      $display("FAIL contend_resp0: got v %b msg %0d expected 10 msg 10",
               {out0_resp_val, out1_resp_val}, out0_resp_msg);
    end
    tick();
    mul_resp_msg = 32'd42;
    #1;
    vectors++;
    if ({out0_resp_val, out1_resp_val} !== 2'b01 || out1_resp_msg !== 32'd42) begin
      miscompares++;
      $display("FAIL contend_resp1: got v %b msg %0d expected 01 msg 42",
               {out0_resp_val, out1_resp_val}, out1_resp_msg);
    end
    tick();
    mul_resp_val = 1'b0;
  endtask

  // Requester 0 sends {k+1, 2}, requester 1 sends {k+1, 3}; the bench plays the
  // multiplier with a one-cycle turnaround so the queue holds one entry throughout.
  task automatic test_sustained();
    int n0, n1, g, prev_port;
    logic [63:0] exp_msg;
    logic [31:0] exp_prod;
    n0 = 0; n1 = 0; prev_port = 0; exp_prod = '0;
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      g = c % 2;
      in0_req_val = (n0 < 4); in0_req_msg = {32'(n0 + 1), 32'd2};
      in1_req_val = (n1 < 4); in1_req_msg = {32'(n1 + 1), 32'd3};
      mul_resp_val = (c > 0); mul_resp_msg = exp_prod;
      exp_msg = (g == 1) ? {32'(n1 + 1), 32'd3} : {32'(n0 + 1), 32'd2};
      #1;
      vectors++;
      if ({in0_req_rdy, in1_req_rdy} !== ((g == 1) ? 2'b01 : 2'b10) || mul_req_msg !== exp_msg)
      begin
        miscompares++;
        $display("FAIL sustain_grant[%0d]: got rdy %b msg %h expected grant %0d msg %h",
                 c, {in0_req_rdy, in1_req_rdy}, mul_req_msg, g, exp_msg);
      end
      if (c > 0) begin
        vectors++;
        if ({out0_resp_val, out1_resp_val} !== ((prev_port == 1) ? 2'b01 : 2'b10) ||
            mul_resp_rdy !== 1'b1) begin
          miscompares++;
          $display("FAIL sustain_route[%0d]: got v %b rdy %b expected port %0d",
                   c, {out0_resp_val, out1_resp_val}, mul_resp_rdy, prev_port);
        end
      end
      prev_port = g;
      if (g == 1) begin
        exp_prod = 32'((n1 + 1) * 3); n1++;
      end else begin
        exp_prod = 32'((n0 + 1) * 2); n0++;
      end
      tick();
    end
    in0_req_val = 1'b0; in1_req_val = 1'b0;
    mul_resp_val = 1'b1; mul_resp_msg = exp_prod;
    #1;
    vectors++;
    if ({out0_resp_val, out1_resp_val} !== 2'b01 || out1_resp_msg !== 32'd12) begin
      miscompares++;
      $display("FAIL sustain_last: got v %b msg %0d expected 01 msg 12",
               {out0_resp_val, out1_resp_val}, out1_resp_msg);
    end
    tick();
    mul_resp_val = 1'b0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    in1_req_val = 1'b1; in1_req_msg = {32'd5, 32'd5};
    tick();
    in1_req_val = 1'b0;
    mul_resp_val = 1'b1; mul_resp_msg = 32'd25;
    out1_resp_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if ({mul_resp_rdy, out0_resp_val, out1_resp_val} !== 3'b001) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: got rdy/v0/v1 %b expected 001",
                 c, {mul_resp_rdy, out0_resp_val, out1_resp_val});
      end
      tick();
    end
    out1_resp_rdy = 1'b1;
    #1;
    vectors++;
    if ({mul_resp_rdy, out1_resp_val} !== 2'b11 || out1_resp_msg !== 32'd25) begin
      miscompares++;
      $display("FAIL backpressure_release: got rdy/v1 %b msg %0d expected 11 msg 25",
               {mul_resp_rdy, out1_resp_val}, out1_resp_msg);
    end
    tick();
    mul_resp_val = 1'b0;
    #1;
    vectors++;
    if (mul_resp_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_single_fire: got resp_rdy %b expected 0", mul_resp_rdy);
    end
  endtask

  task automatic test_full_queue();
    apply_reset();
    in0_req_val = 1'b1; in0_req_msg = {32'd1, 32'd1};
    tick();
    in0_req_msg = {32'd2, 32'd2};
    tick();
    in0_req_msg = {32'd3, 32'd3};
    in1_req_val = 1'b1; in1_req_msg = {32'd4, 32'd4};
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if ({in0_req_rdy, in1_req_rdy, mul_req_val} !== 3'b000) begin
        miscompares++;
        $display("FAIL full_blocked[%0d]: got rdy0/rdy1/val %b expected 000",
                 c, {in0_req_rdy, in1_req_rdy, mul_req_val});
      end
      tick();
    end
    in1_req_val = 1'b0;
    mul_resp_val = 1'b1; mul_resp_msg = 32'd1;
    #1;
    vectors++;
    if ({in0_req_rdy, mul_req_val, out0_resp_val, mul_resp_rdy} !== 4'b0011) begin
      miscompares++;
      $display("FAIL full_no_bypass: got rdy0/val/v0/resp_rdy %b expected 0011",
               {in0_req_rdy, mul_req_val, out0_resp_val, mul_resp_rdy});
    end
    tick();
    mul_resp_msg = 32'd4;
    #1;
    vectors++;
    if ({in0_req_rdy, mul_req_val} !== 2'b11 || mul_req_msg !== {32'd3, 32'd3}) begin
      miscompares++;
      $display("FAIL full_reopen: got rdy0/val %b msg %h expected 11 msg %h",
               {in0_req_rdy, mul_req_val}, mul_req_msg, {32'd3, 32'd3});
    end
    tick();
    in0_req_val = 1'b0;
    mul_resp_msg = 32'd9;
    #1;
    vectors++;
    if ({out0_resp_val, out1_resp_val} !== 2'b10 || out0_resp_msg !== 32'd9) begin
      miscompares++;
      $display("FAIL full_drain: got v %b msg %0d expected 10 msg 9",
               {out0_resp_val, out1_resp_val}, out0_resp_msg);
    end
    tick();
    mul_resp_val = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in0_req_val = 1'b1; in0_req_msg = {32'd6, 32'd7};
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val, out1_resp_val}
        !== 6'b0) begin
      miscompares++;
      $display("FAIL midreset_during: got %b expected 000000",
               {in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val,
                out1_resp_val});
    end
    tick();
    reset = 1'b0;
    in0_req_val = 1'b0;
    #1;
    vectors++;
    if ({dut.prio_q, in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy, out0_resp_val,
         out1_resp_val} !== 7'b0) begin
      miscompares++;
      $display("FAIL midreset_after: got prio+outs %b expected 0000000",
               {dut.prio_q, in0_req_rdy, in1_req_rdy, mul_req_val, mul_resp_rdy,
                out0_resp_val, out1_resp_val});
    end
    in1_req_val = 1'b1; in1_req_msg = {32'd9, 32'd9};
    #1;
    vectors++;
    if ({in0_req_rdy, in1_req_rdy, mul_req_val} !== 3'b011) begin
      miscompares++;
      $display("FAIL midreset_req: got rdy0/rdy1/val %b expected 011",
               {in0_req_rdy, in1_req_rdy, mul_req_val});
    end
    tick();
    in1_req_val = 1'b0;
    mul_resp_val = 1'b1; mul_resp_msg = 32'd81;
    #1;
    vectors++;
    if ({out0_resp_val, out1_resp_val} !== 2'b01 || out1_resp_msg !== 32'd81) begin
      miscompares++;
      $display("FAIL midreset_resp: got v %b msg %0d expected 01 msg 81",
               {out0_resp_val, out1_resp_val}, out1_resp_msg);
    end
    tick();
    mul_resp_val = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_single_port();
    test_contention();
    test_sustained();
    test_backpressure();
    test_full_queue();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lab1_imul_req_arb.md
# lab1_imul_req_arb

Two-port request arbiter and response router placed directly in front of the lab1 integer multiplier. It merges two independent val/rdy requester streams, each carrying 64-bit operand pairs, into the multiplier's single request port. It records which requester issued each accepted operation and steers each 32-bit product back to that requester's response port. Arbitration is round-robin. The block adds zero cycles of latency.

## Interface
Parameters:
- `DEPTH`, default 2: number of in-flight operations tracked in the tag queue. Must be ≥1. 2 covers the fixed-latency multiplier plus one overlapping handshake.

Ports:
- Clocking and reset: reset is synchronous, active-high; the clock is `clk`.
  - `clk`, in, 1: clock.
  - `reset`, in, 1: synchronous active-high reset.
- Requester side:
  - `in0_req_val`, in, 1 / `in0_req_rdy`, out, 1 / `in0_req_msg`, in, 64: requester 0 operands, {a[63:32], b[31:0]}.
  - `in1_req_val`, in, 1 / `in1_req_rdy`, out, 1 / `in1_req_msg`, in, 64: requester 1 operands.
  - `out0_resp_val`, out, 1 / `out0_resp_rdy`, in, 1 / `out0_resp_msg`, out, 32: product to requester 0.
  - `out1_resp_val`, out, 1 / `out1_resp_rdy`, in, 1 / `out1_resp_msg`, out, 32: product to requester 1.
- Multiplier side:
  - `mul_req_val`, out, 1 / `mul_req_rdy`, in, 1 / `mul_req_msg`, out, 64: to the multiplier request port.
  - `mul_resp_val`, in, 1 / `mul_resp_rdy`, out, 1 / `mul_resp_msg`, in, 32: from the multiplier response port.

## Operation
- **State:**
  - 1-bit priority pointer `prio` (0 or 1).
  - Tag queue of `DEPTH` 1-bit entries (requester ID), FIFO order, with full/empty flags.
- **Grant:**
  - If both `inN_req_val` are high, grant port `prio`.
  - If exactly one is high, grant that port.
  - If neither is high, there is no grant.
  - The grant depends only on the val inputs and `prio`, never on any rdy.
- **Request path:**
  - `mul_req_val` = (any `in_req_val`) && !full.
  - `mul_req_msg` = msg of the granted port. When there is no grant it is don't-care, but it is driven to port 0's msg.
  - `inN_req_rdy` = grant==N && `mul_req_rdy` && !full.
- **Request fire** (`mul_req_val` && `mul_req_rdy`):
  - Enqueue the granted ID.
  - Set `prio` to the opposite of the granted port.
- **Full queue:**
  - The request path is blocked whenever the queue is full, even if a dequeue happens in the same cycle. There is no full-queue bypass.
- **Response path:**
  - When the queue is non-empty, head ID H routes responses.
  - `outH_resp_val` = `mul_resp_val`. The other port's resp_val = 0.
  - `mul_resp_rdy` = `outH_resp_rdy`.
  - Both `outN_resp_msg` = `mul_resp_msg`.
  - A response fire dequeues the head.
- **Empty queue:**
  - All `out_resp_val` = 0 and `mul_resp_rdy` = 0.
  - A `mul_resp_val` arriving while the queue is empty is a protocol error. It is ignored, and a simulation-only assertion fires.
- **Same-cycle events:**
  - Enqueue and dequeue in the same cycle on a non-full, non-empty queue are both honoured, and the count is unchanged.
  - A dequeue from a single-entry queue with a simultaneous enqueue leaves one entry: the new ID.

## Timing
- All paths are combinational, so the block adds zero cycles of latency in either direction. The multiplier latency passes through unchanged.
- **Reset:**
  - Sets `prio`=0 and empties the queue (pointers and count 0).
  - Every rdy and val output is 0 during reset, because the queue is empty and both outputs are gated by reset.
- **Reset mid-operation:** in-flight tags are discarded. The multiplier is reset by the same signal, so no stale response is expected.
- **Priority fairness:** when both ports hold val high continuously, grants alternate 0,1,0,1… with one fire per multiplier acceptance.
- **Valid stability:** a requester that deasserts val before its fire loses its grant. `prio` changes only on a fire.
- **Pointer wrap:** queue pointers wrap modulo `DEPTH`. Full is detected as count == `DEPTH`.

## Structure
- **Shared package `lab1_imul_pkg`:**
  - `typedef logic port_id_t`.
  - Constants `PORT0=1'b0` and `PORT1=1'b1`.
  - Message width constants `IMUL_REQ_NBITS=64` and `IMUL_RESP_NBITS=32`.
- **Sub-module `lab1_imul_tag_queue`:**
  - Parameterised `DEPTH`, 1-bit data.
  - Ports `enq_en`, `enq_data`, `deq_en`, `deq_data`, `full`, `empty`.
  - Registered storage with head/tail pointers and a count.
- **Top level:** holds the grant logic, the `prio` register, muxing, and the line trace. The line trace shows the grant, `prio`, and queue occupancy.

## Test plan
- **Single port:** after reset, in0 sends {3,4} with in1 idle. Required: in0_req_rdy=1 on the first cycle `mul_req_rdy`=1. The product 12 appears only on out0 and out1_resp_val stays 0.
- **Contention:** both ports hold val with in0={2,5} and in1={7,6}. Required: grants go in0 then in1, and responses are 10 on out0 then 42 on out1, in that order.
- **Sustained contention:** both ports stream 4 requests each continuously. Required: grants strictly alternate 0,1,0,1…, and every product arrives on the correct port.
- **Response backpressure:** the head tag is port 1 and out1_resp_rdy=0 for 5 cycles. Required: `mul_resp_rdy`=0 for those cycles, out0_resp_val=0, then 1 fire when rdy rises.
- **Full queue:** with `DEPTH`=2, two requests are accepted and no response is drained. Required: both in_req_rdy=0 and `mul_req_val`=0 even while in0 is valid. After one dequeue, requests are accepted again on the next cycle.
- **Reset mid-operation:** assert reset with one tag queued. Required: the queue is empty, `prio`=0, and all val/rdy outputs are 0 on the cycle after reset. A subsequent in1 request {9,9} returns 81 on out1.
